// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for alu_op_sequencer: command opcodes, ALU encodings, FSM states, decode.
// Macro ALU_OP_SEQUENCER_MUL_EN makes command op 5 a legal multiply.
package alu_op_sequencer_pkg;

   typedef enum logic [2:0] {
      CMD_AND  = 3'd0,
      CMD_OR   = 3'd1,
      CMD_ADD  = 3'd2,
      CMD_SUB  = 3'd3,
      CMD_SLT  = 3'd4,
      CMD_MUL  = 3'd5,
      CMD_RSV6 = 3'd6,
      CMD_RSV7 = 3'd7
   } cmd_op_e;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_MUL   = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef struct packed {
      logic [2:0] op;
      logic       cin;
      logic       legal;
      logic       is_mul;
   } alu_ctl_t;

   // Illegal opcodes fall through to an AND with legal cleared.
   function automatic alu_ctl_t decode_op(input logic [2:0] cmd_op);
      alu_ctl_t ctl;
      ctl = '{op: ALU_AND, cin: 1'b0, legal: 1'b0, is_mul: 1'b0};
      case (cmd_op_e'(cmd_op))
         CMD_AND: ctl = '{op: ALU_AND, cin: 1'b0, legal: 1'b1, is_mul: 1'b0};
         CMD_OR:  ctl = '{op: ALU_OR,  cin: 1'b0, legal: 1'b1, is_mul: 1'b0};
         CMD_ADD: ctl = '{op: ALU_ADD, cin: 1'b0, legal: 1'b1, is_mul: 1'b0};
         CMD_SUB: ctl = '{op: ALU_SUB, cin: 1'b1, legal: 1'b1, is_mul: 1'b0};
         CMD_SLT: ctl = '{op: ALU_SLT, cin: 1'b1, legal: 1'b1, is_mul: 1'b0};
`ifdef ALU_OP_SEQUENCER_MUL_EN
         CMD_MUL: ctl = '{op: ALU_ADD, cin: 1'b0, legal: 1'b1, is_mul: 1'b1};
`endif
         default: ctl = '{op: ALU_AND, cin: 1'b0, legal: 1'b0, is_mul: 1'b0};
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/alu_seq_mul_iter.sv
// Shift-add multiply bookkeeping: multiplicand/multiplier shifters, iteration count, sticky carry.
// Only instantiated when ALU_OP_SEQUENCER_MUL_EN is defined.
module alu_seq_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             alu_cout,
   output logic [WIDTH-1:0] addend,
   output logic             done,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] mplier_r;
   logic [CW-1:0]    cnt_r;
   logic             sticky_r;
   logic [WIDTH-1:0] addend_s;

   // Shifters are pre-advanced by one so they always describe the next iteration's addend.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_r  <= '0;
         mplier_r <= '0;
         cnt_r    <= '0;
         sticky_r <= 1'b0;
      end else if (load) begin
         mcand_r  <= a << 1;
         mplier_r <= b >> 1;
         cnt_r    <= '0;
         sticky_r <= 1'b0;
      end else if (step) begin
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
         cnt_r    <= cnt_r + CW'(1);
         sticky_r <= sticky_r | alu_cout;
      end
   end

   // Addend selection for the ALU B operand.
   always_comb begin
      addend_s = '0;
      if (load) begin
         addend_s = b[0] ? a : '0;
      end else begin
         addend_s = mplier_r[0] ? mcand_r : '0;
      end
   end

   assign addend = addend_s;
   assign done   = (cnt_r == CW'(WIDTH - 1));
   assign cout   = sticky_r | alu_cout;

endmodule

// File: rtl/alu_op_sequencer.sv
// Command/response front end for a 32-bit combinational ALU with registered ALU drives.
// Define ALU_OP_SEQUENCER_MUL_EN to add the iterative shift-add multiply (op 5).
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_cout,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag
);
   state_e           state_r;
   state_e           state_s;
   alu_ctl_t         ctl_s;
   logic             accept_s;
   logic             step_s;
   logic             capture_s;
   logic             release_s;
   logic             mul_done_s;
   logic             mul_cout_s;
   logic [WIDTH-1:0] mul_addend_s;

   logic             cmd_ready_r;
   logic [WIDTH-1:0] alu_a_r;
   logic [WIDTH-1:0] alu_b_r;
   logic [2:0]       alu_op_r;
   logic             alu_cin_r;
   logic             err_r;
   logic             rsp_valid_r;
   logic [WIDTH-1:0] rsp_data_r;
   logic             rsp_cout_r;
   logic             rsp_zero_r;
   logic             rsp_err_r;
   logic [TAG_W-1:0] rsp_tag_r;

   assign ctl_s = decode_op(cmd_op);

`ifdef ALU_OP_SEQUENCER_MUL_EN
   alu_seq_mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept_s & ctl_s.is_mul),
      .step     (step_s),
      .a        (cmd_a),
      .b        (cmd_b),
      .alu_cout (alu_cout),
      .addend   (mul_addend_s),
      .done     (mul_done_s),
      .cout     (mul_cout_s)
   );
`else
   assign mul_addend_s = '0;
   assign mul_done_s   = 1'b1;
   assign mul_cout_s   = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = ctl_s.is_mul ? ST_MUL : ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: state_s = ST_RESP;
         ST_MUL: begin
            if (mul_done_s) begin
               state_s = ST_RESP;
            end else begin
               state_s = ST_MUL;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // FSM output strobes driving the datapath registers.
   always_comb begin
      accept_s  = 1'b0;
      step_s    = 1'b0;
      capture_s = 1'b0;
      release_s = 1'b0;
      case (state_r)
         ST_IDLE:  accept_s  = cmd_valid & cmd_ready_r;
         ST_ISSUE: capture_s = 1'b1;
         ST_MUL: begin
            step_s    = 1'b1;
            capture_s = mul_done_s;
         end
         ST_RESP:  release_s = rsp_ready;
         default: begin
            accept_s  = 1'b0;
            capture_s = 1'b0;
         end
      endcase
   end

   // Datapath: ALU drive registers, result capture and response hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready_r <= 1'b0;
         alu_a_r     <= '0;
         alu_b_r     <= '0;
         alu_op_r    <= 3'b000;
         alu_cin_r   <= 1'b0;
         err_r       <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= '0;
         rsp_cout_r  <= 1'b0;
         rsp_zero_r  <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_tag_r   <= '0;
      end else begin
         cmd_ready_r <= (state_s == ST_IDLE);
         if (accept_s) begin
            alu_op_r  <= ctl_s.op;
            alu_cin_r <= ctl_s.cin;
            err_r     <= ~ctl_s.legal;
            rsp_tag_r <= cmd_tag;
            alu_a_r   <= ctl_s.is_mul ? '0 : cmd_a;
            if (ctl_s.is_mul) begin
               alu_b_r <= mul_addend_s;
            end else begin
               alu_b_r <= ctl_s.legal ? cmd_b : '0;
            end
         end else if (step_s && !mul_done_s) begin
            alu_a_r <= alu_result;
            alu_b_r <= mul_addend_s;
         end
         // Illegal requests report a forced zero result regardless of the ALU.
         if (capture_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_r;
            rsp_data_r  <= err_r ? '0 : alu_result;
            rsp_zero_r  <= err_r ? 1'b1 : (alu_result == '0);
            if (err_r) begin
               rsp_cout_r <= 1'b0;
            end else begin
               rsp_cout_r <= (state_r == ST_MUL) ? mul_cout_s : alu_cout;
            end
         end else if (release_s) begin
            rsp_valid_r <= 1'b0;
         end
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign alu_a     = alu_a_r;
   assign alu_b     = alu_b_r;
   assign alu_op    = alu_op_r;
   assign alu_cin   = alu_cin_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_cout  = rsp_cout_r;
   assign rsp_zero  = rsp_zero_r;
   assign rsp_err   = rsp_err_r;
   assign rsp_tag   = rsp_tag_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural 32-bit ALU attached.
// Expectations follow ALU_OP_SEQUENCER_MUL_EN the same way the build does.
module tb_alu_op_sequencer;
   localparam int W = 32;
`ifdef ALU_OP_SEQUENCER_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [2:0]   cmd_op = 3'd0;
   logic [W-1:0] cmd_a = '0;
   logic [W-1:0] cmd_b = '0;
   logic [3:0]   cmd_tag = 4'd0;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [2:0]   alu_op;
   logic         alu_cin, alu_cout;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_data;
   logic         rsp_cout, rsp_zero, rsp_err;
   logic [3:0]   rsp_tag;

   alu_op_sequencer #(.WIDTH(W), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_cout(alu_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
   );

   always #5 clk = ~clk;

   // Behavioural ALU32Bit: adder-based ADD/SUB/SLT, carry 0 for logic ops.
   logic [W:0] sum33;
   always_comb begin
      sum33      = '0;
      alu_result = '0;
      alu_cout   = 1'b0;
      case (alu_op)
         3'b000: alu_result = alu_a & alu_b;
         3'b001: alu_result = alu_a | alu_b;
         3'b010: begin
            sum33 = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
            alu_result = sum33[W-1:0];
            alu_cout   = sum33[W];
         end
         3'b110: begin
            sum33 = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, alu_cin};
            alu_result = sum33[W-1:0];
            alu_cout   = sum33[W];
         end
         3'b111: begin
            sum33 = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, alu_cin};
            alu_result = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            alu_cout   = sum33[W];
         end
         default: alu_result = '0;
      endcase
   end

   typedef struct {
      logic [W-1:0] data;
      logic         cout, zero, err;
      logic [3:0]   tag;
      int           lat;
      int           acc;
      logic [2:0]   aop;
      logic         acin;
      logic [W-1:0] aa, ab;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   hold_req = 0;
   int   hold_left = 0;
   bit   pending = 1'b0;
   bit   released = 1'b0;
   logic [W+6:0] snap;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Reference: arithmetic straight from the opcode table.
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] tag);
      exp_t e;
      logic [63:0]  p;
      logic [W:0]   s;
      logic [W-1:0] acc, add;
      bit           illegal;
      illegal = 1'b0;
      e.data = '0; e.cout = 1'b0; e.err = 1'b0; e.tag = tag; e.lat = 1; e.acc = 0;
      e.aop = 3'b000; e.acin = 1'b0; e.aa = a; e.ab = b;
      case (op)
         3'd0: e.data = a & b;
         3'd1: begin e.data = a | b; e.aop = 3'b001; end
         3'd2: begin s = {1'b0, a} + {1'b0, b}; e.data = s[W-1:0]; e.cout = s[W]; e.aop = 3'b010; end
         3'd3: begin e.data = a - b; e.cout = (a >= b); e.aop = 3'b110; e.acin = 1'b1; end
         3'd4: begin
            e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            e.cout = (a >= b); e.aop = 3'b111; e.acin = 1'b1;
         end
         3'd5: begin
            if (MUL_EN) begin
               p = {32'd0, a} * {32'd0, b};
               e.data = p[W-1:0];
               acc = '0;
               for (int i = 0; i < W; i++) begin
                  add = b[i] ? (a << i) : '0;
                  s = {1'b0, acc} + {1'b0, add};
                  e.cout |= s[W];
                  acc = s[W-1:0];
               end
               e.lat = W; e.aop = 3'b010; e.aa = '0; e.ab = b[0] ? a : '0;
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         e.data = '0; e.cout = 1'b0; e.err = 1'b1; e.ab = '0;
      end
      e.zero = (e.data == '0);
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] tag);
      exp_t e;
      int   w;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
      w = 0;
      while (!cmd_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) begin
         check("cmd_ready_timeout", {63'd0, cmd_ready}, 64'd1);
         cmd_valid = 1'b0;
      end else begin
         e = model(op, a, b, tag);
         e.acc = cyc + 1;
         exp_q.push_back(e);
         @(posedge clk);
         @(negedge clk);
         cmd_valid = 1'b0;
         check("alu_op_drive", {61'd0, alu_op}, {61'd0, e.aop});
         check("alu_cin_drive", {63'd0, alu_cin}, {63'd0, e.acin});
         check("alu_ab_drive", {alu_a, alu_b}, {e.aa, e.ab});
      end
   endtask

   // Monitor: pops the scoreboard on each new response and checks the hold behaviour.
   always @(negedge clk) begin
      if (!rst_n) begin
         pending = 1'b0; hold_left = 0; released = 1'b0; rsp_ready = 1'b0;
      end else if (released) begin
         check("cmd_ready_after_release", {63'd0, cmd_ready}, 64'd1);
         check("rsp_valid_dropped", {63'd0, rsp_valid}, 64'd0);
         released = 1'b0;
      end else if (rsp_valid) begin
         if (!pending) begin
            if (exp_q.size() == 0) begin
               check("unexpected_response", {60'd0, rsp_tag}, 64'hFFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check("rsp_data", {32'd0, rsp_data}, {32'd0, mon_e.data});
               check("rsp_flags", {61'd0, rsp_cout, rsp_zero, rsp_err},
                     {61'd0, mon_e.cout, mon_e.zero, mon_e.err});
               check("rsp_tag", {60'd0, rsp_tag}, {60'd0, mon_e.tag});
               check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
            pending = 1'b1;
            snap = {rsp_data, rsp_cout, rsp_zero, rsp_err, rsp_tag};
            if (hold_req > 0) begin
               hold_left = hold_req;
               hold_req  = 0;
            end
         end else begin
            check("rsp_hold_stable", {25'd0, rsp_data, rsp_cout, rsp_zero, rsp_err, rsp_tag},
                  {25'd0, snap});
         end
         check("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
         if (hold_left > 0) begin
            rsp_ready = 1'b0;
            hold_left--;
         end else begin
            rsp_ready = 1'($urandom_range(0, 1));
         end
         if (rsp_ready) begin
            pending  = 1'b0;
            released = 1'b1;
         end
      end else begin
         rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int w;
      logic [2:0] op;
      #12;
      check("reset_outputs", {cmd_ready, rsp_valid, rsp_cout, rsp_zero, rsp_err, rsp_tag, alu_op, alu_cin,
                              rsp_data[22:0]}, 64'd0);
      check("reset_alu_ab", {alu_a, alu_b}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("cmd_ready_after_reset", {63'd0, cmd_ready}, 64'd1);

      issue(3'd0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 4'd3);
      issue(3'd3, 32'h2000_0000, 32'h1000_0000, 4'd4);
      issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 4'd5);
      issue(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 4'd6);
      issue(3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 4'd7);
      issue(3'd5, 32'h0000_1234, 32'h0000_0010, 4'd8);
      hold_req = 10;
      issue(3'd1, 32'hA5A5_0000, 32'h0000_5A5A, 4'd1);

      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         issue(op, pick(), pick(), 4'($urandom_range(0, 15)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      w = 0;
      while ((exp_q.size() != 0 || pending) && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("drain_before_reset", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of a long operation: everything must clear, nothing stale returns.
      hold_req = 1000;
      issue(3'd5, 32'h0000_1234, 32'h0000_0010, 4'd9);
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {cmd_ready, rsp_valid, rsp_cout, rsp_zero, rsp_err, rsp_tag, alu_op,
                                    alu_cin, alu_a[22:0]}, 64'd0);
      check("async_reset_data", {rsp_data, alu_b}, 64'd0);
      exp_q.delete();
      hold_req = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("no_stale_response", {63'd0, rsp_valid}, 64'd0);
      issue(3'd2, 32'h0000_0005, 32'h0000_0007, 4'd10);

      w = 0;
      while ((exp_q.size() != 0 || pending) && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("final_drain", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
